cpu_mem_responder: RTL and testbench
====================================

Name: cpu_mem_responder

Overview:
- Memory-side responder for the custom CPU's data memory channels: request channel (Address/MemWrite/Write_data/Write_strb/MemRead/Mem_Req_Ready) and read-data response channel (Read_data/Read_data_Valid/Read_data_Ready).
- Backs requests with an internal word-addressed RAM.
- Returns read data in order after a fixed pipeline latency, through a credit-limited response FIFO.
- Used as the simulation/FPGA memory model behind the pipelined core, and exports access counters.

Parameters:
- ADDR_WIDTH, 10: word-index bits of the internal RAM (2^ADDR_WIDTH 32-bit words).
- READ_LATENCY, 2: cycles from read accept to the earliest Read_data_Valid. Legal range 1..8.
- RESP_DEPTH, 4: maximum outstanding reads (power of 2, 2..16). Also the response FIFO depth.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous reset, active-low.
- Address  in  32  byte address; word index = Address[ADDR_WIDTH+1:2]; other bits ignored.
- MemWrite  in  1  write request.
- Write_data  in  32  write data.
- Write_strb  in  4  byte enables; bit i covers bits [8i+7:8i].
- MemRead  in  1  read request.
- Mem_Req_Ready  out  1  request accepted when (MemRead|MemWrite)&Mem_Req_Ready.
- Read_data  out  32  response data.
- Read_data_Valid  out  1  response valid.
- Read_data_Ready  in  1  CPU accepts response.
- rd_cnt  out  32  accepted reads, wraps at 2^32.
- wr_cnt  out  32  accepted writes, wraps at 2^32.
- proto_err  out  1  sticky: MemRead and MemWrite both high on an accepted request.

Behaviour:
- Reset (rst==0 at posedge):
  - Outputs: Mem_Req_Ready=0, Read_data_Valid=0, Read_data=0, rd_cnt=0, wr_cnt=0, proto_err=0.
  - Internal state: outstanding=0, FIFO pointers cleared, all latency-pipe valid bits cleared.
  - RAM contents are not reset.
  - Reset mid-operation discards all in-flight and queued reads.
- Mem_Req_Ready: registered-state function = !in_reset && (outstanding < RESP_DEPTH). Same-cycle pops do not raise it; it rises the cycle after.
- Write accept:
  - Bytes with Write_strb=1 are updated at the accepting edge; Write_strb=0000 is a legal no-op.
  - wr_cnt += 1.
  - No response is generated.
- Read accept:
  - The RAM word is sampled combinationally in the accept cycle, so a read accepted the cycle after a write to the same word returns the new data.
  - The sampled word enters a READ_LATENCY-1 stage shift pipe (no stall, advances every cycle), then is pushed into the FIFO.
  - Accepted in cycle n into an empty FIFO -> Read_data_Valid=1 in cycle n+READ_LATENCY.
  - rd_cnt += 1; outstanding += 1.
- Response:
  - Read_data_Valid = FIFO non-empty; Read_data = FIFO head (0 when empty).
  - Pop on Read_data_Valid&Read_data_Ready; outstanding -= 1.
  - Read_data and Read_data_Valid must hold stable while Valid=1 and Ready=0.
- Outstanding counter:
  - Width clog2(RESP_DEPTH)+1.
  - Simultaneous read accept and pop in the same cycle -> unchanged.
  - The credit rule guarantees the FIFO never overflows; a push into a full FIFO is an assertion failure.
- Ordering: responses are returned strictly in accept order; FIFO pointers wrap modulo RESP_DEPTH.
- MemRead&MemWrite both high on accept:
  - Treated as a write only; wr_cnt increments.
  - No read response; proto_err set until reset.
- Requests presented while Mem_Req_Ready=0 are ignored: no side effects, no counter change.

Test Plan:
- Write 0xDEADBEEF to 0x40, strb 1111; next cycle read 0x40 (accept cycle n) -> Read_data_Valid=1 and Read_data=0xDEADBEEF in cycle n+2; rd_cnt=1, wr_cnt=1.
- Word 0x80 holds 0xAAAAAAAA; write 0x11223344 strb 0101; read 0x80 -> 0xAA22AA44.
- Read_data_Ready=0; issue reads to 0x0,0x4,0x8,0xC,0x10 back-to-back -> first 4 accepted, Mem_Req_Ready=0 from the cycle after the 4th accept; raise Ready -> 4 responses in address order, then 5th accepted the cycle after the first pop.
- Steady stream, Read_data_Ready=1, one read per cycle -> Mem_Req_Ready stays 1, one response per cycle, outstanding never exceeds READ_LATENCY.
- MemRead=MemWrite=1, Address 0x20, data 0x5, strb 1111 -> word 0x20 = 0x5, no Read_data_Valid, proto_err=1, wr_cnt+1, rd_cnt unchanged.
- Two reads in flight; rst=0 for one cycle -> next cycle Read_data_Valid=0, Mem_Req_Ready=0, counters 0; after rst=1, Mem_Req_Ready=1 and no stale responses appear; previously written RAM data is still readable.

Source files
------------

// File: rtl/cpu_mem_responder.sv
// Data-memory responder for the pipelined core: word RAM behind a request channel,
// with in-order read responses delivered through a fixed-latency pipe and a credit-limited FIFO.
module cpu_mem_responder #(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 2,
  parameter int RESP_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  input  logic        MemRead,
  output logic        Mem_Req_Ready,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ready,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt,
  output logic        proto_err
);

  // Handshakes: a request transfers on a posedge where (MemRead|MemWrite) & Mem_Req_Ready;
  // a response transfers on a posedge where Read_data_Valid & Read_data_Ready, and
  // Read_data/Read_data_Valid stay stable while Valid is high and Ready is low.

  localparam int PW     = $clog2(RESP_DEPTH);
  localparam int OW     = PW + 1;
  localparam int STAGES = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;
  localparam logic [OW-1:0] DEPTH_C = OW'(RESP_DEPTH);

  logic [31:0]           ram [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           ram_rdata;
  logic                  addr_unused;

  logic                  in_reset;
  logic [OW-1:0]         outstanding;
  logic                  wr_acc;
  logic                  rd_acc;

  logic [STAGES-1:0]     pv;
  logic [31:0]           pd [STAGES];
  logic                  push_v;
  logic [31:0]           push_d;

  logic [31:0]           fifo_mem [RESP_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [OW-1:0]         fifo_cnt;
  logic                  pop;

  assign word_idx    = Address[ADDR_WIDTH+1:2];
  assign addr_unused = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};
  assign ram_rdata   = ram[word_idx];

  // Credit is taken from registered state only, so a pop frees a slot one cycle later.
  assign Mem_Req_Ready = !in_reset && (outstanding < DEPTH_C);

  // A combined read+write request is served as a write only.
  assign wr_acc = rst & MemWrite & Mem_Req_Ready;
  assign rd_acc = rst & MemRead & ~MemWrite & Mem_Req_Ready;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int b = 0; b < 4; b++) begin
        if (Write_strb[b]) ram[word_idx][8*b +: 8] <= Write_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pv <= '0;
    end else begin
      pv[0] <= rd_acc;
      for (int s = 1; s < STAGES; s++) pv[s] <= pv[s-1];
    end
  end

  always_ff @(posedge clk) begin
    pd[0] <= ram_rdata;
    for (int s = 1; s < STAGES; s++) pd[s] <= pd[s-1];
  end

  assign push_v = (READ_LATENCY == 1) ? rd_acc    : pv[STAGES-1];
  assign push_d = (READ_LATENCY == 1) ? ram_rdata : pd[STAGES-1];

  assign Read_data_Valid = (fifo_cnt != '0);
  assign Read_data       = Read_data_Valid ? fifo_mem[rd_ptr] : 32'h0;
  assign pop             = Read_data_Valid & Read_data_Ready;

  always_ff @(posedge clk) begin
    if (push_v) fifo_mem[wr_ptr] <= push_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      assert (!(push_v && !pop && fifo_cnt == DEPTH_C))
        else $error("response FIFO overflow");
      if (push_v) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + OW'(push_v) - OW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      in_reset    <= 1'b1;
      outstanding <= '0;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
      proto_err   <= 1'b0;
    end else begin
      in_reset    <= 1'b0;
      outstanding <= outstanding + OW'(rd_acc) - OW'(pop);
      if (rd_acc) rd_cnt <= rd_cnt + 32'd1;
      if (wr_acc) wr_cnt <= wr_cnt + 32'd1;
      if (wr_acc && MemRead) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: latency, byte strobes, credit back-pressure,
// streaming, combined read/write and mid-flight reset.
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] Address = '0;
  logic        MemWrite = 1'b0;
  logic [31:0] Write_data = '0;
  logic [3:0]  Write_strb = '0;
  logic        MemRead = 1'b0;
  logic        Mem_Req_Ready;
  logic [31:0] Read_data;
  logic        Read_data_Valid;
  logic        Read_data_Ready = 1'b0;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  logic        proto_err;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  cpu_mem_responder #(.ADDR_WIDTH(10), .READ_LATENCY(2), .RESP_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .Address(Address), .MemWrite(MemWrite),
    .Write_data(Write_data), .Write_strb(Write_strb), .MemRead(MemRead),
    .Mem_Req_Ready(Mem_Req_Ready), .Read_data(Read_data),
    .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!Mem_Req_Ready && n < 50) begin
      step();
      n++;
    end
    if (!Mem_Req_Ready) check("ready_timeout", 32'(Mem_Req_Ready), 32'd1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    Address = addr; Write_data = data; Write_strb = strb; MemWrite = 1'b1;
    wait_ready();
    step();
    MemWrite = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr);
    Address = addr; MemRead = 1'b1;
    wait_ready();
    step();
    MemRead = 1'b0;
  endtask

  // Read with Read_data_Ready high; response expected two cycles after accept.
  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    Read_data_Ready = 1'b1;
    do_read(addr);
    check({tag, "_early"}, 32'(Read_data_Valid), 32'd0);
    step();
    check({tag, "_vld"}, 32'(Read_data_Valid), 32'd1);
    check({tag, "_dat"}, Read_data, exp);
    step();
  endtask

  initial begin
    // Reset
    step(); step();
    check("rst_ready", 32'(Mem_Req_Ready), 32'd0);
    check("rst_vld", 32'(Read_data_Valid), 32'd0);
    check("rst_data", Read_data, 32'h0);
    check("rst_rdcnt", rd_cnt, 32'd0);
    check("rst_wrcnt", wr_cnt, 32'd0);
    check("rst_perr", 32'(proto_err), 32'd0);
    rst = 1'b1;
    step();
    check("post_rst_ready", 32'(Mem_Req_Ready), 32'd1);

    // Write then read next cycle, latency 2, hold while not ready
    do_write(32'h40, 32'hDEADBEEF, 4'hF);
    do_read(32'h40);
    check("t1_n1_vld", 32'(Read_data_Valid), 32'd0);
    step();
    check("t1_n2_vld", 32'(Read_data_Valid), 32'd1);
    check("t1_n2_dat", Read_data, 32'hDEADBEEF);
    check("t1_rdcnt", rd_cnt, 32'd1);
    check("t1_wrcnt", wr_cnt, 32'd1);
    step();
    check("t1_hold_vld", 32'(Read_data_Valid), 32'd1);
    check("t1_hold_dat", Read_data, 32'hDEADBEEF);
    Read_data_Ready = 1'b1;
    step();
    check("t1_popped", 32'(Read_data_Valid), 32'd0);

    // Byte strobes and the all-zero strobe no-op
    do_write(32'h80, 32'hAAAAAAAA, 4'hF);
    do_write(32'h80, 32'h11223344, 4'b0101);
    do_write(32'h80, 32'hFFFFFFFF, 4'b0000);
    read_check("t2", 32'h80, 32'hAA22AA44);
    check("t2_wrcnt", wr_cnt, 32'd4);
    check("t2_rdcnt", rd_cnt, 32'd2);

    // Credit back-pressure with 5 back-to-back reads
    for (int i = 0; i < 5; i++) do_write(32'(4*i), 32'h100 + 32'(i), 4'hF);
    Read_data_Ready = 1'b0;
    MemRead = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Address = 32'(4*i);
      check($sformatf("t3_rdy%0d", i), 32'(Mem_Req_Ready), 32'd1);
      step();
    end
    Address = 32'h10;
    check("t3_full_rdy", 32'(Mem_Req_Ready), 32'd0);
    step(); step();
    check("t3_full_rdy2", 32'(Mem_Req_Ready), 32'd0);
    check("t3_rdcnt_held", rd_cnt, 32'd6);
    Read_data_Ready = 1'b1;
    check("t3_dat0", Read_data, 32'h100);
    check("t3_pop_rdy", 32'(Mem_Req_Ready), 32'd0);
    step();
    check("t3_dat1", Read_data, 32'h101);
    check("t3_reopen_rdy", 32'(Mem_Req_Ready), 32'd1);
    check("t3_rdcnt_pre5", rd_cnt, 32'd6);
    step();
    MemRead = 1'b0;
    check("t3_rdcnt5", rd_cnt, 32'd7);
    check("t3_dat2", Read_data, 32'h102);
    step();
    check("t3_dat3", Read_data, 32'h103);
    step();
    check("t3_vld4", 32'(Read_data_Valid), 32'd1);
    check("t3_dat4", Read_data, 32'h104);
    step();
    check("t3_drained", 32'(Read_data_Valid), 32'd0);

    // Steady stream, one read and one response per cycle
    Read_data_Ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i < 12) begin
        MemRead = 1'b1;
        Address = 32'(4 * (i % 5));
        check($sformatf("t4_rdy%0d", i), 32'(Mem_Req_Ready), 32'd1);
        exp_q.push_back(32'h100 + 32'(i % 5));
      end else begin
        MemRead = 1'b0;
      end
      if (i >= 2) begin
        check($sformatf("t4_vld%0d", i), 32'(Read_data_Valid), 32'd1);
        if (exp_q.size() > 0) check($sformatf("t4_dat%0d", i), Read_data, exp_q.pop_front());
      end
      step();
    end
    check("t4_idle", 32'(Read_data_Valid), 32'd0);
    check("t4_rdcnt", rd_cnt, 32'd19);

    // Combined read+write request is a write only
    Address = 32'h20; Write_data = 32'h5; Write_strb = 4'hF;
    MemWrite = 1'b1; MemRead = 1'b1;
    step();
    MemWrite = 1'b0; MemRead = 1'b0;
    check("t5_vld_a", 32'(Read_data_Valid), 32'd0);
    step();
    check("t5_vld_b", 32'(Read_data_Valid), 32'd0);
    step();
    check("t5_vld_c", 32'(Read_data_Valid), 32'd0);
    check("t5_perr", 32'(proto_err), 32'd1);
    check("t5_wrcnt", wr_cnt, 32'd10);
    check("t5_rdcnt", rd_cnt, 32'd19);
    read_check("t5_word", 32'h20, 32'h5);
    check("t5_perr_sticky", 32'(proto_err), 32'd1);

    // Reset with two reads in flight
    Read_data_Ready = 1'b0;
    MemRead = 1'b1;
    Address = 32'h40;
    step();
    Address = 32'h80;
    step();
    MemRead = 1'b0;
    rst = 1'b0;
    step();
    check("t6_vld", 32'(Read_data_Valid), 32'd0);
    check("t6_rdy", 32'(Mem_Req_Ready), 32'd0);
    check("t6_rdcnt", rd_cnt, 32'd0);
    check("t6_wrcnt", wr_cnt, 32'd0);
    check("t6_perr", 32'(proto_err), 32'd0);
    rst = 1'b1;
    step();
    check("t6_rdy_after", 32'(Mem_Req_Ready), 32'd1);
    Read_data_Ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t6_stale%0d", i), 32'(Read_data_Valid), 32'd0);
      step();
    end
    read_check("t6_ram", 32'h40, 32'hDEADBEEF);
    check("t6_rdcnt_after", rd_cnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
